nor_bist_checker: RTL and testbench
===================================

Name: nor_bist_checker

Overview:
- Hardware stimulus/response end of the WIDTH-bit bitwise NOR interface. It drives operand pairs into a NOR unit, then receives and checks the result.
- It walks every op1/op2 combination exhaustively, computes the expected ~(op1|op2) internally, and compares it with the DUT result after a fixed latency.
- It counts mismatches and captures the first failing vector.
- Sits beside the NOR unit as a built-in self-test engine, replacing the simulation-only checker loop.

Parameters:
- WIDTH, 4: operand and result width; the number of vectors is 2^(2*WIDTH).
- LATENCY, 0: DUT result delay in clock cycles after operands are presented. 0 means a combinational DUT.
- ERR_W, 16: error counter width; the counter saturates.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  single-cycle pulse that starts a test run.
- o_op1  output  WIDTH  operand 1 to the DUT (registered).
- o_op2  output  WIDTH  operand 2 to the DUT (registered).
- i_result  input  WIDTH  NOR result returned by the DUT.
- o_busy  output  1  high while in RUN or DRAIN.
- o_done  output  1  high in DONE.
- o_pass  output  1  high in DONE when o_err_cnt==0.
- o_err_cnt  output  ERR_W  number of mismatching vectors, saturating.
- o_first_err_valid  output  1  a first-error capture is held.
- o_first_err_op1  output  WIDTH  op1 of the first mismatch.
- o_first_err_op2  output  WIDTH  op2 of the first mismatch.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; all counters and pipelines cleared. A reset mid-run aborts the run with no partial result kept.
- FSM states: IDLE -> RUN -> DRAIN -> DONE.
  - IDLE: i_start moves to RUN and clears the error counter and first-error capture.
  - RUN: one vector per cycle. Vector index n is a 2*WIDTH-bit counter: o_op1 = n[2W-1:W] (outer loop), o_op2 = n[W-1:0] (inner loop). First vector is op1=0, op2=0.
  - RUN to DRAIN: after the all-ones vector has been driven for one cycle. With LATENCY=0, go directly to DONE.
  - DRAIN: lasts exactly LATENCY cycles, then moves to DONE.
  - DONE: outputs hold until the next i_start (restart as from IDLE) or reset.
- i_start is ignored in RUN and DRAIN.
- Timing: vector n is driven during cycle n of RUN. i_result for vector n is sampled at the rising edge ending cycle n+LATENCY.
- Expected-value pipeline:
  - Depth LATENCY+1; carries expected value, op1, op2 and a valid bit.
  - Compare only when the valid bit is set. Bubbles in DRAIN carry valid=0.
- Mismatch rule: any bit of i_result differs from the expected value → that vector is one error.
  - o_err_cnt increments by 1, saturating at 2^ERR_W-1.
  - If o_first_err_valid==0: capture op1/op2 and set o_first_err_valid. Later errors never overwrite the capture.
- Run length: o_done rises 2^(2W)+LATENCY cycles after the cycle in which i_start was sampled. o_pass is valid only when o_done=1, otherwise 0.
- o_op1/o_op2 hold their last values in DRAIN and DONE; they return to 0 only on reset or restart.
- Wrap-around: the vector counter wraps from all-ones to 0 only on restart, never mid-run.

Test Plan:
- WIDTH=4, LATENCY=0, correct combinational NOR DUT, pulse i_start → o_busy for 256 cycles, then o_done=1, o_pass=1, o_err_cnt=0, o_first_err_valid=0.
- Same setup, DUT result bit0 stuck at 0 → o_err_cnt=64 (the vectors with op1[0]=op2[0]=0), o_pass=0, first error op1=0 op2=0.
- WIDTH=4, LATENCY=2, DUT with a 2-stage register pipeline → o_done at cycle 258 after start, o_pass=1. The same DUT with LATENCY=1 configured → o_err_cnt>0.
- ERR_W=4, DUT output forced to 4'hF → o_err_cnt saturates at 15, first error op1=0 op2=1.
- i_start pulsed again at vector 50 → ignored, o_done still at cycle 256. Second i_start in DONE → counters cleared, full rerun passes.
- Assert i_rst at vector 100, between edges → all outputs 0 immediately, state IDLE. After release, i_start → complete 256-vector run with o_pass=1.

Source files
------------

// File: rtl/nor_bist_checker.sv
`default_nettype none
// ---- nor_bist_checker : exhaustive stimulus/response self-test for a WIDTH-bit NOR unit ----
// ---- rev 1.0 ----
module nor_bist_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 0,
  parameter int ERR_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_op1,
  output logic [WIDTH-1:0] o_op2,
  input  logic [WIDTH-1:0] i_result,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_first_err_valid,
  output logic [WIDTH-1:0] o_first_err_op1,
  output logic [WIDTH-1:0] o_first_err_op2
);

  localparam int NW = 2 * WIDTH;
  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ERR_W-1:0] C_ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    vec_q, vec_d;
  logic             run_v_q, run_v_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fev_q, fev_d;
  logic [WIDTH-1:0] fe1_q, fe1_d;
  logic [WIDTH-1:0] fe2_q, fe2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  stage_t w_s0;
  stage_t w_tail;
  logic   w_mis;

  // Stage 0 is the vector currently on the output registers.
  always_comb begin
    w_s0.v = run_v_q;
    w_s0.a = vec_q[NW-1:WIDTH];
    w_s0.b = vec_q[WIDTH-1:0];
    w_s0.e = ~(vec_q[NW-1:WIDTH] | vec_q[WIDTH-1:0]);
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign w_tail = w_s0;
    end else begin : g_pipe
      stage_t pipe_q [LATENCY];
      stage_t pipe_d [LATENCY];

      always_comb begin
        pipe_d[0] = w_s0;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < LATENCY; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign w_tail = pipe_q[LATENCY-1];
    end
  endgenerate

  assign w_mis = w_tail.v && (i_result != w_tail.e);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    run_v_d = run_v_q;
    drain_d = drain_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fe1_d   = fe1_q;
    fe2_d   = fe2_q;

    if (w_mis) begin
      if (err_q != C_ERR_MAX) err_d = err_q + 1'b1;
      if (!fev_q) begin
        fev_d = 1'b1;
        fe1_d = w_tail.a;
        fe2_d = w_tail.b;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_RUN;
          vec_d   = '0;
          run_v_d = 1'b1;
          err_d   = '0;
          fev_d   = 1'b0;
          fe1_d   = '0;
          fe2_d   = '0;
        end
      end
      S_RUN: begin
        if (&vec_q) begin
          run_v_d = 1'b0;
          drain_d = '0;
          state_d = (LATENCY == 0) ? S_DONE : S_DRAIN;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(LATENCY - 1)) state_d = S_DONE;
        else                             drain_d = drain_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_d == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      run_v_q <= 1'b0;
      drain_q <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fe1_q   <= '0;
      fe2_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      run_v_q <= run_v_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fe1_q   <= fe1_d;
      fe2_q   <= fe2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign o_op1             = vec_q[NW-1:WIDTH];
  assign o_op2             = vec_q[WIDTH-1:0];
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_pass            = pass_q;
  assign o_err_cnt         = err_q;
  assign o_first_err_valid = fev_q;
  assign o_first_err_op1   = fe1_q;
  assign o_first_err_op2   = fe2_q;

endmodule
`default_nettype wire

// File: tb/tb_nor_bist_checker.sv
`default_nettype none
// ---- tb_nor_bist_checker : directed + randomized-fault bench for nor_bist_checker ----
// ---- rev 1.0 ----
module tb_nor_bist_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start2 = 1'b0;
  logic [3:0]  op1_0, op2_0, res0, fe1_0, fe2_0;
  logic [3:0]  op1_2, op2_2, res2, fe1_2, fe2_2;
  logic        busy0, done0, pass0, fev0;
  logic        busy2, done2, pass2, fev2;
  logic [15:0] err0;
  logic [3:0]  err2;

  int total = 0;
  int bad   = 0;
  int mode0 = 0;
  int mode2 = 0;
  bit depth2_full = 1'b1;
  logic [3:0] mask [256];
  logic [3:0] r1 = '0, r2 = '0;

  // Behaviour of the NOR unit under test: 0 good, 1 bit0 stuck low, 2 stuck 4'hF, 3 random fault table.
  function automatic logic [3:0] fn(int mode, logic [3:0] a, logic [3:0] b);
    logic [3:0] good;
    good = ~(a | b);
    case (mode)
      1:       return good & 4'hE;
      2:       return 4'hF;
      3:       return good ^ mask[{a, b}];
      default: return good;
    endcase
  endfunction

  always_comb res0 = fn(mode0, op1_0, op2_0);

  always @(posedge clk) begin
    r1 <= fn(mode2, op1_2, op2_2);
    r2 <= r1;
  end
  assign res2 = depth2_full ? r2 : r1;

  nor_bist_checker #(.WIDTH(4), .LATENCY(0), .ERR_W(16)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_op1(op1_0), .o_op2(op2_0),
    .i_result(res0), .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_cnt(err0),
    .o_first_err_valid(fev0), .o_first_err_op1(fe1_0), .o_first_err_op2(fe2_0));

  nor_bist_checker #(.WIDTH(4), .LATENCY(2), .ERR_W(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .o_op1(op1_2), .o_op2(op2_2),
    .i_result(res2), .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_cnt(err2),
    .o_first_err_valid(fev2), .o_first_err_op1(fe1_2), .o_first_err_op2(fe2_2));

  int          sel = 0;
  logic        s_busy, s_done, s_pass, s_fev;
  logic [3:0]  s_op1, s_op2, s_fe1, s_fe2;
  logic [15:0] s_err;
  always_comb begin
    s_busy = sel != 0 ? busy2 : busy0;
    s_done = sel != 0 ? done2 : done0;
    s_pass = sel != 0 ? pass2 : pass0;
    s_fev  = sel != 0 ? fev2  : fev0;
    s_op1  = sel != 0 ? op1_2 : op1_0;
    s_op2  = sel != 0 ? op2_2 : op2_0;
    s_fe1  = sel != 0 ? fe1_2 : fe1_0;
    s_fe2  = sel != 0 ? fe2_2 : fe2_0;
    s_err  = sel != 0 ? {12'd0, err2} : err0;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk all 256 operand pairs in order, count faulty ones, keep the first.
  task automatic model(int mode, int sat, output int errs, output int f1, output int f2);
    errs = 0; f1 = -1; f2 = -1;
    for (int idx = 0; idx < 256; idx++) begin
      logic [3:0] a, b;
      a = 4'(idx / 16);
      b = 4'(idx % 16);
      if (fn(mode, a, b) !== ~(a | b)) begin
        if (f1 < 0) begin f1 = a; f2 = b; end
        errs++;
      end
    end
    if (errs > sat) errs = sat;
  endtask

  task automatic pulse_start(int which);
    if (which != 0) start2 = 1'b1; else start0 = 1'b1;
  endtask

  task automatic run(int which, int exp_cyc, int poke, string tag);
    int cyc;
    sel = which;
    @(negedge clk);
    pulse_start(which);
    @(negedge clk);
    start0 = 1'b0; start2 = 1'b0;
    cyc = 0;
    check({tag, "_busy"}, 32'(s_busy), 32'd1);
    while (!s_done && cyc < 2000) begin
      if (cyc == poke) begin
        check({tag, "_op1_mid"}, 32'(s_op1), 32'(poke / 16));
        check({tag, "_op2_mid"}, 32'(s_op2), 32'(poke % 16));
        check({tag, "_pass_mid"}, 32'(s_pass), 32'd0);
        pulse_start(which);
      end
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0;
      cyc++;
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_end"}, 32'(s_busy), 32'd0);
  endtask

  task automatic verify(string tag, int errs, int f1, int f2);
    check({tag, "_done"}, 32'(s_done), 32'd1);
    check({tag, "_pass"}, 32'(s_pass), 32'(errs == 0));
    check({tag, "_err"}, 32'(s_err), 32'(errs));
    check({tag, "_fev"}, 32'(s_fev), 32'(errs != 0));
    if (errs != 0) begin
      check({tag, "_fe1"}, 32'(s_fe1), 32'(f1));
      check({tag, "_fe2"}, 32'(s_fe2), 32'(f2));
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_busy"}, 32'(s_busy), 32'd0);
    check({tag, "_done"}, 32'(s_done), 32'd0);
    check({tag, "_pass"}, 32'(s_pass), 32'd0);
    check({tag, "_err"},  32'(s_err),  32'd0);
    check({tag, "_fev"},  32'(s_fev),  32'd0);
    check({tag, "_ops"},  32'({s_op1, s_op2, s_fe1, s_fe2}), 32'd0);
  endtask

  task automatic randomize_mask();
    for (int i = 0; i < 256; i++) begin
      mask[i] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    end
  endtask

  initial begin
    int e, f1, f2;
    for (int i = 0; i < 256; i++) mask[i] = 4'd0;

    #1 rst = 1'b1;
    #1;
    sel = 0; check_zero("rst_u0");
    sel = 1; check_zero("rst_u2");
    @(negedge clk); rst = 1'b0;

    mode0 = 0;
    run(0, 256, -1, "ok0");
    verify("ok0", 0, 0, 0);
    check("ok0_hold_ops", 32'({s_op1, s_op2}), 32'hFF);
    repeat (3) @(negedge clk);
    check("ok0_hold_done", 32'({s_done, s_pass}), 32'b11);

    mode0 = 1;
    run(0, 256, -1, "stuck0");
    verify("stuck0", 64, 0, 0);

    mode0 = 0;
    run(0, 256, 50, "restart");
    verify("restart", 0, 0, 0);

    mode0 = 2;
    run(0, 256, -1, "forcef0");
    verify("forcef0", 255, 0, 1);

    mode0 = 3;
    for (int k = 0; k < 2; k++) begin
      randomize_mask();
      model(3, 65535, e, f1, f2);
      run(0, 256, -1, "rnd0");
      verify("rnd0", e, f1, f2);
    end

    mode0 = 0;
    sel = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_ops", 32'({s_op1, s_op2}), 32'h64);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk); rst = 1'b0;
    run(0, 256, -1, "postrst");
    verify("postrst", 0, 0, 0);

    mode2 = 0; depth2_full = 1'b1;
    run(1, 258, -1, "lat2_ok");
    verify("lat2_ok", 0, 0, 0);

    mode2 = 2;
    run(1, 258, -1, "lat2_sat");
    verify("lat2_sat", 15, 0, 1);

    mode2 = 3;
    randomize_mask();
    model(3, 15, e, f1, f2);
    run(1, 258, -1, "lat2_rnd");
    verify("lat2_rnd", e, f1, f2);

    mode2 = 0; depth2_full = 1'b0;
    run(1, 258, -1, "lat_mis");
    check("lat_mis_err_nonzero", 32'(s_err != 16'd0), 32'd1);
    check("lat_mis_pass", 32'(s_pass), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
